uart_rx: RTL
============

Name: uart_rx

Overview:
Serial UART receiver: 8N1 frames, LSB first, idle-high line. It is the downstream partner of uart_tx and consumes its serial_tx output, in loopback benches and on the board.
It synchronises the asynchronous line and samples each bit at mid-period. It then presents each received byte through a hold-until-acknowledged interface, with framing-error and overrun reporting.

Parameters:
CLKS_PER_BIT, 868, clk cycles per bit (115200 baud at 100 MHz); legal range >= 4; sets counter width (clog2).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
serial_rx  input  1  asynchronous serial line, idle high
data_out  output  8  last accepted byte
data_valid  output  1  high while data_out holds an unacknowledged byte
data_ack  input  1  consumer acknowledge; clears data_valid
frame_error  output  1  one-clock pulse: stop bit sampled low
overrun  output  1  one-clock pulse: frame completed while data_valid high
busy  output  1  high whenever FSM not in IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IDLE.
  - Both synchroniser flops to 1.
  - data_out=8'h00; data_valid, frame_error, overrun, busy = 0.
  - Bit counter and index cleared.
  - A reset mid-frame abandons the frame silently.
- Synchroniser: 2-flop chain on serial_rx, giving rx_s. All decisions use rx_s only (2-clk latency).
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: on rx_s=0, go to START with clk_cnt=0.
  - START: count to CLKS_PER_BIT/2-1 (integer division).
    - Midpoint rx_s=0: go to DATA; clk_cnt=0, bit_idx=0.
    - Midpoint rx_s=1: glitch; return to IDLE with no flag.
  - DATA: on clk_cnt=CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first) and reset clk_cnt.
    - After bit_idx=7 is sampled, go to STOP.
  - STOP: on clk_cnt=CLKS_PER_BIT-1, sample the stop bit.
    - Stop=1: frame good; go to IDLE.
    - Stop=0: pulse frame_error one clock; discard byte; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. A break condition never retriggers a start.
- Timing: the stop sample occurs CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks after START entry. Output flags update on the following clock edge.
- Good-frame delivery:
  - data_valid=0, or data_ack=1 in the same cycle: data_out <= shift; data_valid=1.
  - data_valid=1 and no ack: data_out unchanged; new byte dropped; overrun pulses one clock.
- data_ack:
  - With data_valid=1 and no frame completing: data_valid 0 next clock.
  - With data_valid=0: ignored.
  - Held high across cycles: harmless.
- busy = (state != IDLE), registered with the state.
- Back-to-back frames: the FSM returns to IDLE at mid-stop bit, so a start edge right after the stop bit is caught. Tolerates ±2% baud mismatch.
- Flag independence: frame_error and overrun are never both asserted in one cycle.

Test Plan:
- Loopback with uart_tx, both CLKS_PER_BIT=16; send 8'hAA -> data_valid rises 152..156 clocks after serial_rx falls, data_out=8'hAA. Ack -> data_valid low next clock.
- Direct-drive 8'h01, 8'h80, 8'hFF, 8'h00 at CLKS_PER_BIT=16 -> each received exactly, LSB first. No frame_error, no overrun.
- Low pulse of 5 clocks on idle line -> FSM returns to IDLE by clock 10. No data_valid, no frame_error.
- Frame 8'h55 with stop bit driven low, line held low 40 more clocks -> one frame_error pulse, data_valid stays 0. busy stays high until line goes high, then the next frame 8'h3C is received correctly.
- Two frames 8'h11 then 8'h22, no ack -> data_out=8'h11, one overrun pulse at second stop sample. Repeat with data_ack at the completion cycle -> data_out=8'h22, data_valid stays 1, no overrun.
- Assert reset low for 3 clocks mid-DATA (bit 4) -> all outputs 0 immediately. Next full frame 8'hC3 received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx: 8N1 UART receiver (LSB first, idle-high line).
//
// Synchronises the asynchronous serial line through a two-flop chain. It
// qualifies the start bit at its midpoint and then samples each data bit and
// the stop bit one bit period apart, so every sample lands mid-bit. Each
// received byte is held on data_out until the consumer acknowledges it.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   serial_rx   in   asynchronous serial line, idle high
//   data_out    out  [7:0] last accepted byte
//   data_valid  out  high while data_out holds an unacknowledged byte
//   data_ack    in   consumer acknowledge; clears data_valid
//   frame_error out  one-clock pulse: stop bit sampled low
//   overrun     out  one-clock pulse: frame completed while data_valid high
//   busy        out  high whenever the FSM is not in IDLE
//
// Handshake: data_valid rises when a good frame is accepted and stays high
// until a cycle with data_ack=1 is seen. If a new frame completes in the same
// cycle as the ack, the new byte replaces the old one and data_valid stays
// high. If a frame completes while data_valid=1 and there is no ack, the new
// byte is dropped and overrun pulses. data_ack while data_valid=0 is ignored.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic          r_sync1;
  logic          r_sync2;
  logic          w_rx_s;
  logic [2:0]    r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data_out;
  logic          r_data_valid;
  logic          r_frame_error;
  logic          r_overrun;
  logic          r_busy;

  // Both synchroniser flops reset high so the line reads as idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= serial_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_clk_cnt     <= '0;
      r_bit_idx     <= 3'd0;
      r_shift       <= 8'h00;
      r_data_out    <= 8'h00;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;

      // Plain acknowledge; a good frame completing this cycle overrides it.
      if (r_data_valid && data_ack) begin
        r_data_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state   <= S_START;
            r_busy    <= 1'b1;
            r_clk_cnt <= '0;
          end
        end

        S_START: begin
          if (r_clk_cnt == HALF_CNT) begin
            r_clk_cnt <= '0;
            if (!w_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= 3'd0;
            end else begin
              // Line back high at mid-start: a glitch, not a frame.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (r_clk_cnt == LAST_CNT) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (r_clk_cnt == LAST_CNT) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
              // Returning to IDLE at mid-stop lets a back-to-back start
              // edge be caught.
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              if (!r_data_valid || data_ack) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
              end else begin
                r_overrun <= 1'b1;
              end
            end else begin
              r_frame_error <= 1'b1;
              r_state       <= S_WAIT_HIGH;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        S_WAIT_HIGH: begin
          // A held-low (break) line must not be taken as a new start bit.
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign frame_error = r_frame_error;
  assign overrun     = r_overrun;
  assign busy        = r_busy;

endmodule
